mux2_arbiter: RTL

MUX2_ARBITER -- requirements
Module: mux2_arbiter

---
 rtl/mux2_arbiter_pkg.sv | 16 +
 rtl/mux2.sv | 18 +
 rtl/mux2_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mux2_arbiter_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
//   state_t : arbiter FSM states (IDLE, OWN_A, OWN_B)
//   SEL_A   : mux select value for requester A
//   SEL_B   : mux select value for requester B
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2.sv
// Two-input, W-bit combinational multiplexer built from and/or terms.
// Ports:
//   a   : input  [W-1:0]  data selected when sel=0
//   b   : input  [W-1:0]  data selected when sel=1
//   sel : input           select
//   z   : output [W-1:0]  (sel & b) | (a & ~sel)
module mux2 #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] z
);

    assign z = ({W{sel}} & b) | (a & {W{~sel}});

endmodule

// File: rtl/mux2_arbiter.sv
// Arbiter granting one of two requesters ownership of a shared mux, with
// bursts of at most BURST consecutive granted cycles per ownership. The
// selected beat is registered into dout one cycle after each granted cycle.
//
// Build option: define MUX2_ARB_RR_EN for round-robin tie-breaking (the
// requester that did not own the most recent burst wins). Without it,
// requester A always wins ties, including against a B re-burst.
//
// Ports:
//   clk        : input           clock, rising edge
//   rst        : input           synchronous active-high reset
//   req_a      : input           requester A wants the mux
//   req_b      : input           requester B wants the mux
//   din_a      : input  [W-1:0]  requester A data (select 0)
//   din_b      : input  [W-1:0]  requester B data (select 1)
//   gnt_a      : output          A owns the mux this cycle
//   gnt_b      : output          B owns the mux this cycle
//   sel        : output          registered mux select, 0=A, 1=B
//   dout       : output [W-1:0]  registered mux output
//   dout_valid : output          dout carries a granted beat
//
// state | meaning
// IDLE  | no owner, sel holds its last value
// OWN_A | A granted, cnt counts beats of the current burst
// OWN_B | B granted, cnt counts beats of the current burst
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int W     = 1,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic         req_b,
    input  logic [W-1:0] din_a,
    input  logic [W-1:0] din_b,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         sel,
    output logic [W-1:0] dout,
    output logic         dout_valid
);

    localparam int             CW       = $clog2(BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    state_t        state, state_nxt, pick;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          sel_nxt;
    logic          owner_req;
    logic          decide;
    logic          gnt_any;
    logic [W-1:0]  mux_z;
`ifdef MUX2_ARB_RR_EN
    logic          last_owner, last_owner_nxt;
`endif

    assign gnt_a   = (state == OWN_A);
    assign gnt_b   = (state == OWN_B);
    assign gnt_any = gnt_a | gnt_b;

    // Owner chosen whenever a decision is due (from IDLE or at ownership end).
    always_comb begin
        pick = IDLE;
        if (req_a && req_b) begin
`ifdef MUX2_ARB_RR_EN
            pick = (last_owner == SEL_B) ? OWN_A : OWN_B;
`else
            pick = OWN_A;
`endif
        end else if (req_a) begin
            pick = OWN_A;
        end else if (req_b) begin
            pick = OWN_B;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        decide    = 1'b0;
        owner_req = (state == OWN_A) ? req_a : req_b;
`ifdef MUX2_ARB_RR_EN
        last_owner_nxt = last_owner;
`endif
        case (state)
            IDLE: decide = 1'b1;
            OWN_A, OWN_B: begin
                if (!owner_req || cnt == CNT_LAST) begin
                    decide = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A decision into an OWN state is always a fresh burst, even when
        // the same owner re-acquires the mux.
        if (decide) begin
            state_nxt = pick;
            cnt_nxt   = '0;
            if (pick == OWN_A) begin
                sel_nxt = SEL_A;
`ifdef MUX2_ARB_RR_EN
                last_owner_nxt = SEL_A;
`endif
            end else if (pick == OWN_B) begin
                sel_nxt = SEL_B;
`ifdef MUX2_ARB_RR_EN
                last_owner_nxt = SEL_B;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= SEL_A;
            dout       <= '0;
            dout_valid <= 1'b0;
`ifdef MUX2_ARB_RR_EN
            last_owner <= SEL_B;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            dout_valid <= gnt_any;
            if (gnt_any) begin
                dout <= mux_z;
            end
`ifdef MUX2_ARB_RR_EN
            last_owner <= last_owner_nxt;
`endif
        end
    end

    mux2 #(.W(W)) u_mux2 (
        .a   (din_a),
        .b   (din_b),
        .sel (sel),
        .z   (mux_z)
    );

endmodule
